esd_stage_sequencer: RTL and testbench

//   Sequences the staged de-energize / re-energize of N final elements (valves,

---
 rtl/esd_stage_sequencer.sv | 172 +++++++++++++++++
 tb/tb_esd_stage_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/esd_stage_sequencer.sv
// Staged de-energize / re-energize sequencer for ESD final elements.
// Each stage gets a fixed dwell with a feedback confirm window; any feedback failure latches a fault.
module esd_stage_sequencer #(
    parameter int CLK_HZ         = 24000000,
    parameter int N_STAGES       = 4,
    parameter int STAGE_DELAY_MS = 100,
    parameter int FB_TIMEOUT_MS  = 50,
    localparam int IDX_W = (N_STAGES > 2) ? $clog2(N_STAGES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                shutdown_i,
    input  logic                ack_pulse_i,
    input  logic [N_STAGES-1:0] fb_i,
    output logic [N_STAGES-1:0] stage_o,
    output logic                busy_o,
    output logic                all_on_o,
    output logic                all_off_o,
    output logic                seq_fault_o,
    output logic [IDX_W-1:0]    fault_stage_o
);

    localparam int DLY   = CLK_HZ / 1000 * STAGE_DELAY_MS;
    localparam int TO    = CLK_HZ / 1000 * FB_TIMEOUT_MS;
    localparam int TMR_W = (DLY > 1) ? $clog2(DLY) : 1;

    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_STAGES - 1);
    localparam logic [TMR_W-1:0] T_CHK = TMR_W'(TO - 1);
    localparam logic [TMR_W-1:0] T_END = TMR_W'(DLY - 1);

    if (N_STAGES < 2) begin : g_bad_stages
        $error("esd_stage_sequencer: N_STAGES must be >= 2");
    end
    if (TO < 1 || TO > DLY) begin : g_bad_timeout
        $error("esd_stage_sequencer: feedback window must satisfy 1 <= TO <= DLY");
    end

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_STARTUP = 3'd1,
        S_RUN     = 3'd2,
        S_SHUTDN  = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [TMR_W-1:0] tmr;
    logic             flt;
    logic [3:0]       status;

    logic             at_chk, at_end, fb_sel, sd_fb_fail;
    logic [IDX_W-1:0] idx_up, idx_dn;

    assign at_chk     = (tmr == T_CHK);
    assign at_end     = (tmr == T_END);
    assign fb_sel     = fb_i[idx];
    assign sd_fb_fail = at_chk && fb_sel;
    assign idx_up     = idx + IDX_W'(1);
    assign idx_dn     = idx - IDX_W'(1);

    assign {busy_o, all_on_o, all_off_o, seq_fault_o} = status;

    // {busy, all_on, all_off, seq_fault} for the state being entered
    function automatic logic [3:0] status_of(input state_t s);
        case (s)
            S_STARTUP, S_SHUTDN: return 4'b1000;
            S_RUN:               return 4'b0100;
            S_OFF:               return 4'b0010;
            default:             return 4'b0001;
        endcase
    endfunction

    // NOTE: status is loaded together with every state change so the flags come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_OFF;
            status        <= status_of(S_OFF);
            idx           <= '0;
            tmr           <= '0;
            flt           <= 1'b0;
            stage_o       <= '0;
            fault_stage_o <= '0;
        end else begin
            case (state)
                S_OFF: begin
                    stage_o <= '0;
                    if (ack_pulse_i && !shutdown_i) begin
                        state   <= S_STARTUP;
                        status  <= status_of(S_STARTUP);
                        idx     <= '0;
                        tmr     <= '0;
                        stage_o <= N_STAGES'(1);
                    end
                end

                S_STARTUP: begin
                    if (shutdown_i) begin
                        state        <= S_SHUTDN;
                        status       <= status_of(S_SHUTDN);
                        tmr          <= '0;
                        stage_o[idx] <= 1'b0;
                    end else if (at_chk && !fb_sel) begin
                        state         <= S_FAULT;
                        status        <= status_of(S_FAULT);
                        fault_stage_o <= idx;
                        stage_o       <= '0;
                    end else if (at_end) begin
                        if (idx == LAST) begin
                            state   <= S_RUN;
                            status  <= status_of(S_RUN);
                            stage_o <= '1;
                        end else begin
                            idx             <= idx_up;
                            tmr             <= '0;
                            stage_o[idx_up] <= 1'b1;
                        end
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end

                S_RUN: begin
                    if (shutdown_i) begin
                        state             <= S_SHUTDN;
                        status            <= status_of(S_SHUTDN);
                        idx               <= LAST;
                        tmr               <= '0;
                        stage_o[LAST]     <= 1'b0;
                    end
                end

                S_SHUTDN: begin
                    // A stage that stays energized is recorded, but release never stops
                    if (sd_fb_fail) begin
                        flt <= 1'b1;
                        if (!flt) fault_stage_o <= idx;
                    end
                    if (at_end) begin
                        if (idx == '0) begin
                            state   <= (flt || sd_fb_fail) ? S_FAULT : S_OFF;
                            status  <= status_of((flt || sd_fb_fail) ? S_FAULT : S_OFF);
                            stage_o <= '0;
                        end else begin
                            idx             <= idx_dn;
                            tmr             <= '0;
                            stage_o[idx_dn] <= 1'b0;
                        end
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end

                S_FAULT: begin
                    stage_o <= '0;
                    if (ack_pulse_i && fb_i == '0) begin
                        state  <= S_OFF;
                        status <= status_of(S_OFF);
                        flt    <= 1'b0;
                    end
                end

                default: begin
                    state   <= S_FAULT;
                    status  <= status_of(S_FAULT);
                    stage_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_esd_stage_sequencer.sv
// Bench for esd_stage_sequencer: directed sequence timing plus randomized stimulus
// against a timeline model (stage pattern derived from elapsed time since sequence start).
module tb_esd_stage_sequencer;

    localparam int N     = 4;
    localparam int DLY   = 8;
    localparam int TO    = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             shutdown_i = 1'b0;
    logic             ack_pulse_i = 1'b0;
    logic [N-1:0]     fb_i = '0;
    logic [N-1:0]     stage_o;
    logic             busy_o, all_on_o, all_off_o, seq_fault_o;
    logic [IDX_W-1:0] fault_stage_o;

    esd_stage_sequencer #(
        .CLK_HZ(1000), .N_STAGES(N), .STAGE_DELAY_MS(8), .FB_TIMEOUT_MS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .shutdown_i(shutdown_i), .ack_pulse_i(ack_pulse_i),
        .fb_i(fb_i), .stage_o(stage_o), .busy_o(busy_o), .all_on_o(all_on_o),
        .all_off_o(all_off_o), .seq_fault_o(seq_fault_o), .fault_stage_o(fault_stage_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode plus the cycle the current sequence started
    typedef enum {M_OFF, M_UP, M_RUN, M_DOWN, M_FAULT} mode_t;
    mode_t        m_mode = M_OFF;
    int           m_t0 = 0, m_from = 0, m_fidx = 0, cyc = 0;
    bit           m_flt = 1'b0;
    logic [N-1:0] h1 = '0, h2 = '0, stuck0 = '0, stuck1 = '0;

    task automatic model_reset();
        m_mode = M_OFF;
        m_flt  = 1'b0;
        m_fidx = 0;
        m_t0   = cyc;
    endtask

    // Decide the mode for the next cycle from the inputs seen in cycle cyc
    task automatic model_edge();
        int e, k, ph, cur;
        e   = cyc - m_t0;
        k   = e / DLY;
        ph  = e % DLY;
        cur = m_from - k;
        case (m_mode)
            M_OFF: if (ack_pulse_i && !shutdown_i) begin m_mode = M_UP; m_t0 = cyc + 1; end
            M_UP: begin
                if (shutdown_i) begin
                    m_mode = M_DOWN; m_from = k; m_t0 = cyc + 1;
                end else if (ph == TO - 1 && !fb_i[k]) begin
                    m_mode = M_FAULT; m_fidx = k;
                end else if (ph == DLY - 1 && k == N - 1) begin
                    m_mode = M_RUN;
                end
            end
            M_RUN: if (shutdown_i) begin m_mode = M_DOWN; m_from = N - 1; m_t0 = cyc + 1; end
            M_DOWN: begin
                if (ph == TO - 1 && fb_i[cur]) begin
                    if (!m_flt) m_fidx = cur;
                    m_flt = 1'b1;
                end
                if (ph == DLY - 1 && cur == 0) m_mode = m_flt ? M_FAULT : M_OFF;
            end
            M_FAULT: if (ack_pulse_i && fb_i == '0) begin m_mode = M_OFF; m_flt = 1'b0; end
        endcase
    endtask

    // Expected {stage, busy, all_on, all_off, seq_fault} in cycle cyc
    function automatic logic [N+3:0] model_out();
        int k;
        k = (cyc - m_t0) / DLY;
        case (m_mode)
            M_UP:    return {N'((1 << (k + 1)) - 1), 4'b1000};
            M_RUN:   return {{N{1'b1}}, 4'b0100};
            M_DOWN:  return {N'((1 << (m_from - k)) - 1), 4'b1000};
            M_FAULT: return {{N{1'b0}}, 4'b0001};
            default: return {{N{1'b0}}, 4'b0010};
        endcase
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        cyc++;
        #1;
        check("outs", {stage_o, busy_o, all_on_o, all_off_o, seq_fault_o}, model_out());
        if (m_mode == M_FAULT) check("fault_stage", fault_stage_o, m_fidx);
        // actuator plant: feedback follows the drive two cycles late
        fb_i = (h2 & ~stuck0) | stuck1;
        h2 = h1;
        h1 = stage_o;
        ack_pulse_i = 1'b0;
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        check("rst_stage", stage_o, 0);
        check("rst_all_off", all_off_o, 1);
        check("rst_flags", {busy_o, all_on_o, seq_fault_o, fault_stage_o}, 0);
        model_reset();
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
        h1 = '0;
        h2 = '0;
        fb_i = stuck1;
        ack_pulse_i = 1'b0;
    endtask

    function automatic logic flag(input int sel);
        case (sel)
            0:       return all_on_o;
            1:       return all_off_o;
            default: return seq_fault_o;
        endcase
    endfunction

    // Run until the selected flag rises (bounded) and check cycles since t_ref
    task automatic run_until(input string tag, input int sel, input int t_ref, input int want);
        int n;
        n = 0;
        while (!flag(sel) && n < 100) begin
            tick();
            n++;
        end
        check(tag, flag(sel) ? cyc - t_ref : -1, want);
    endtask

    initial begin
        int t;
        @(posedge clk);
        #1;
        async_reset();

        // startup: all_on 33 cycles after the ack cycle
        t = cyc; ack_pulse_i = 1'b1; tick();
        check("s1_first_stage", stage_o, 4'b0001);
        run_until("s1_all_on_at", 0, t, 33);

        // shutdown from RUN: descending release, all_off 33 cycles later
        t = cyc; shutdown_i = 1'b1; tick();
        check("s2_first_release", stage_o, 4'b0111);
        run_until("s2_all_off_at", 1, t, 33);
        shutdown_i = 1'b0; tick();

        // startup with stage 1 feedback stuck low
        stuck0 = 4'b0010;
        t = cyc; ack_pulse_i = 1'b1; tick();
        run_until("s3_fault_at", 2, t, 13);
        check("s3_fault_stage", fault_stage_o, 1);
        check("s3_stage_off", stage_o, 0);
        stuck0 = '0;
        repeat (3) tick();
        ack_pulse_i = 1'b1; tick();
        check("s3_ack_to_off", all_off_o, 1);

        // abort at tmr 5 of startup step 2
        t = cyc; ack_pulse_i = 1'b1; tick();
        repeat (21) tick();
        check("s4_pre_abort", stage_o, 4'b0111);
        t = cyc; shutdown_i = 1'b1; tick();
        check("s4_abort_release", stage_o, 4'b0011);
        run_until("s4_all_off_at", 1, t, 25);
        shutdown_i = 1'b0; tick();

        // shutdown with stage 3 feedback stuck high
        t = cyc; ack_pulse_i = 1'b1; tick();
        run_until("s5_all_on_at", 0, t, 33);
        stuck1 = 4'b1000; tick();
        t = cyc; shutdown_i = 1'b1; tick();
        run_until("s5_fault_at", 2, t, 33);
        check("s5_fault_stage", fault_stage_o, 3);
        ack_pulse_i = 1'b1; tick();
        check("s5_ack_ignored", seq_fault_o, 1);
        stuck1 = '0;
        repeat (3) tick();
        ack_pulse_i = 1'b1; tick();
        check("s5_ack_taken", all_off_o, 1);
        shutdown_i = 1'b0; tick();

        // asynchronous reset mid-startup, then ack blocked by shutdown
        ack_pulse_i = 1'b1; tick();
        repeat (9) tick();
        check("s6_pre_reset", stage_o, 4'b0011);
        async_reset();
        shutdown_i = 1'b1; ack_pulse_i = 1'b1; tick();
        check("s6_ack_blocked", {all_off_o, busy_o}, 2'b10);
        shutdown_i = 1'b0; tick();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            if (shutdown_i ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 69) == 0))
                shutdown_i = ~shutdown_i;
            if ($urandom_range(0, 9) == 0) ack_pulse_i = 1'b1;
            r = $urandom_range(0, 299);
            if (r == 0)      stuck0 = N'($urandom_range(1, 15));
            else if (r == 1) stuck1 = N'($urandom_range(1, 15));
            else if (r < 7) begin stuck0 = '0; stuck1 = '0; end
            if ($urandom_range(0, 999) == 0) async_reset();
            else tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
